// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit up-counter with compare match, overflow flag and level irq.
// Occupies a 16-byte window at BASE: CTRL, COUNT, COMPARE, STATUS.
module mmio_timer #(
    parameter logic [31:0] BASE = 32'h0000_0400
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    output logic [31:0] rd,
    output logic        hit,
    output logic        irq
);

    logic        ctrlEn;
    logic        ctrlAutoReload;
    logic        ctrlIrqEn;
    logic [7:0]  prescale;
    logic [7:0]  pre;
    logic [31:0] count;
    logic [31:0] compare;
    logic        statusMatch;
    logic        statusOvf;

    logic        wrCtrl;
    logic        wrCount;
    logic        wrCompare;
    logic        wrStatus;
    logic        tick;
    logic        countEqCompare;
    logic        reload;
    logic        setMatch;
    logic        setOvf;
    logic [32:0] countInc;
    logic        unusedAddrBits;

    assign hit            = (addr[31:4] == BASE[31:4]);
    assign unusedAddrBits = ^addr[1:0];

    assign wrCtrl    = we && hit && (addr[3:2] == 2'd0);
    assign wrCount   = we && hit && (addr[3:2] == 2'd1);
    assign wrCompare = we && hit && (addr[3:2] == 2'd2);
    assign wrStatus  = we && hit && (addr[3:2] == 2'd3);

    assign tick           = ctrlEn && (pre == prescale);
    assign countEqCompare = (count == compare);
    assign reload         = countEqCompare && ctrlAutoReload;
    assign countInc       = {1'b0, count} + 33'd1;

    // A COUNT write in a tick cycle suppresses the tick's flag updates entirely.
    assign setMatch = tick && !wrCount && countEqCompare;
    assign setOvf   = tick && !wrCount && !reload && countInc[32];

    assign irq = ctrlIrqEn && statusMatch;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrlEn         <= 1'b0;
            ctrlAutoReload <= 1'b0;
            ctrlIrqEn      <= 1'b0;
            prescale       <= 8'd0;
            pre            <= 8'd0;
            count          <= 32'd0;
            compare        <= 32'd0;
            statusMatch    <= 1'b0;
            statusOvf      <= 1'b0;
        end else begin
            if (wrCtrl) begin
                ctrlEn         <= wd[0];
                ctrlAutoReload <= wd[1];
                ctrlIrqEn      <= wd[2];
                prescale       <= wd[15:8];
            end

            if (wrCompare) begin
                compare <= wd;
            end

            if (!ctrlEn || wrCount || tick) begin
                pre <= 8'd0;
            end else begin
                pre <= pre + 8'd1;
            end

            if (wrCount) begin
                count <= wd;
            end else if (tick) begin
                count <= reload ? 32'd0 : countInc[31:0];
            end

            // Hardware set takes priority over a simultaneous write-1-clear.
            statusMatch <= setMatch || (statusMatch && !(wrStatus && wd[0]));
            statusOvf   <= setOvf   || (statusOvf   && !(wrStatus && wd[1]));
        end
    end

    always_comb begin
        rd = 32'd0;
        if (hit) begin
            case (addr[3:2])
                2'd0:    rd = {16'd0, prescale, 5'd0, ctrlIrqEn, ctrlAutoReload, ctrlEn};
                2'd1:    rd = count;
                2'd2:    rd = compare;
                default: rd = {30'd0, statusOvf, statusMatch};
            endcase
        end
    end

endmodule
